// File: rtl/i2c_axil_pkg.sv
// rtl/i2c_axil_pkg.sv - shared response codes, state encoding and index-width helper for the channel router
package i2c_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef logic [2:0] router_state_t;

   localparam router_state_t ST_IDLE      = 3'd0;
   localparam router_state_t ST_WR_FWD    = 3'd1;
   localparam router_state_t ST_WR_WAIT_B = 3'd2;
   localparam router_state_t ST_WR_RESP   = 3'd3;
   localparam router_state_t ST_RD_FWD    = 3'd4;
   localparam router_state_t ST_RD_WAIT_R = 3'd5;
   localparam router_state_t ST_RD_RESP   = 3'd6;

   // A single channel still needs a 1-bit index register.
   function automatic int ch_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2c_axil_chan_router_if.sv
// rtl/i2c_axil_chan_router_if.sv - AXI-lite bundle of N lanes, lane c occupying slice c of every field
interface i2c_axil_chan_router_if #(
   parameter int N      = 1,
   parameter int ADDR_W = 8
) ();
   logic [N*ADDR_W-1:0] awaddr;
   logic [N*3-1:0]      awprot;
   logic [N-1:0]        awvalid;
   logic [N-1:0]        awready;
   logic [N*32-1:0]     wdata;
   logic [N*4-1:0]      wstrb;
   logic [N-1:0]        wvalid;
   logic [N-1:0]        wready;
   logic [N*2-1:0]      bresp;
   logic [N-1:0]        bvalid;
   logic [N-1:0]        bready;
   logic [N*ADDR_W-1:0] araddr;
   logic [N*3-1:0]      arprot;
   logic [N-1:0]        arvalid;
   logic [N-1:0]        arready;
   logic [N*32-1:0]     rdata;
   logic [N*2-1:0]      rresp;
   logic [N-1:0]        rvalid;
   logic [N-1:0]        rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/i2c_axil_chan_router.sv
// rtl/i2c_axil_chan_router.sv - one-outstanding AXI-lite fan-out to N_CH I2C master channels with watchdog
module i2c_axil_chan_router
   import i2c_axil_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int CH_ADDR_W = 4,
   parameter int S_ADDR_W  = 8,
   parameter int TIMEOUT   = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   i2c_axil_chan_router_if.slave  s_axil,
   i2c_axil_chan_router_if.master m_axil,
   output logic [N_CH-1:0]        ch_timeout
);

   localparam int IDX_W = ch_idx_w(N_CH);
   localparam int UP_W  = S_ADDR_W - CH_ADDR_W;

   router_state_t        state_q, state_d;
   logic [IDX_W-1:0]     ch_q, ch_d;
   logic [CH_ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]           prot_q, prot_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           wstrb_q, wstrb_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [1:0]           resp_q, resp_d;
   logic [31:0]          wdog_q, wdog_d;
   logic                 aw_done_q, aw_done_d;
   logic                 w_done_q, w_done_d;
   logic                 lww_q, lww_d;
   logic [N_CH-1:0]      to_q, to_d;

   logic [UP_W-1:0] aw_up, ar_up;
   logic            wr_pend, rd_pend, idle, grant_wr, grant_rd;
   logic            aw_dec_err, ar_dec_err, in_flight, expire;
   logic            sel_aw_hs, sel_w_hs, sel_ar_hs, sel_bvalid, sel_rvalid;

   logic [N_CH-1:0] awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;
   logic [1:0]      ch_bresp [N_CH];
   logic [1:0]      ch_rresp [N_CH];
   logic [31:0]     ch_rdata [N_CH];

   // The whole upper field is decoded so out-of-range windows return DECERR.
   assign aw_up      = s_axil.awaddr[S_ADDR_W-1:CH_ADDR_W];
   assign ar_up      = s_axil.araddr[S_ADDR_W-1:CH_ADDR_W];
   assign aw_dec_err = 32'(aw_up) >= 32'(N_CH);
   assign ar_dec_err = 32'(ar_up) >= 32'(N_CH);

   assign wr_pend  = s_axil.awvalid[0] & s_axil.wvalid[0];
   assign rd_pend  = s_axil.arvalid[0];
   assign idle     = (state_q == ST_IDLE) && !rst;
   assign grant_wr = idle && wr_pend && (!rd_pend || !lww_q);
   assign grant_rd = idle && rd_pend && (!wr_pend || lww_q);

   assign in_flight = (state_q == ST_WR_FWD) || (state_q == ST_WR_WAIT_B) ||
                      (state_q == ST_RD_FWD) || (state_q == ST_RD_WAIT_R);
   assign expire    = in_flight && (wdog_q == 32'(TIMEOUT - 1));

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic hit;
      assign hit          = (ch_q == IDX_W'(c)) && !expire;
      assign awvalid_v[c] = hit && (state_q == ST_WR_FWD) && !aw_done_q;
      assign wvalid_v[c]  = hit && (state_q == ST_WR_FWD) && !w_done_q;
      assign bready_v[c]  = hit && (state_q == ST_WR_WAIT_B);
      assign arvalid_v[c] = hit && (state_q == ST_RD_FWD);
      assign rready_v[c]  = hit && (state_q == ST_RD_WAIT_R);
      assign ch_bresp[c]  = m_axil.bresp[2*c +: 2];
      assign ch_rresp[c]  = m_axil.rresp[2*c +: 2];
      assign ch_rdata[c]  = m_axil.rdata[32*c +: 32];
   end

   assign m_axil.awvalid = awvalid_v;
   assign m_axil.wvalid  = wvalid_v;
   assign m_axil.bready  = bready_v;
   assign m_axil.arvalid = arvalid_v;
   assign m_axil.rready  = rready_v;
   assign m_axil.awaddr  = {N_CH{addr_q}};
   assign m_axil.araddr  = {N_CH{addr_q}};
   assign m_axil.awprot  = {N_CH{prot_q}};
   assign m_axil.arprot  = {N_CH{prot_q}};
   assign m_axil.wdata   = {N_CH{wdata_q}};
   assign m_axil.wstrb   = {N_CH{wstrb_q}};

   assign sel_aw_hs  = awvalid_v[ch_q] & m_axil.awready[ch_q];
   assign sel_w_hs   = wvalid_v[ch_q] & m_axil.wready[ch_q];
   assign sel_ar_hs  = arvalid_v[ch_q] & m_axil.arready[ch_q];
   assign sel_bvalid = bready_v[ch_q] & m_axil.bvalid[ch_q];
   assign sel_rvalid = rready_v[ch_q] & m_axil.rvalid[ch_q];

   assign s_axil.awready = grant_wr;
   assign s_axil.wready  = grant_wr;
   assign s_axil.arready = grant_rd;
   assign s_axil.bvalid  = (state_q == ST_WR_RESP);
   assign s_axil.rvalid  = (state_q == ST_RD_RESP);
   assign s_axil.bresp   = resp_q;
   assign s_axil.rresp   = resp_q;
   assign s_axil.rdata   = rdata_q;
   assign ch_timeout     = to_q;

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      lww_d     = lww_q;
      to_d      = to_q;
      wdog_d    = in_flight ? wdog_q + 32'd1 : wdog_q;
      if (expire) begin
         // Any downstream response landing in this cycle is deliberately dropped.
         to_d[ch_q] = 1'b1;
         resp_d     = RESP_SLVERR;
         rdata_d    = '0;
         state_d    = ((state_q == ST_WR_FWD) || (state_q == ST_WR_WAIT_B)) ? ST_WR_RESP : ST_RD_RESP;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_wr) begin
                  ch_d      = aw_up[IDX_W-1:0];
                  addr_d    = s_axil.awaddr[CH_ADDR_W-1:0];
                  prot_d    = s_axil.awprot;
                  wdata_d   = s_axil.wdata;
                  wstrb_d   = s_axil.wstrb;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  wdog_d    = '0;
                  lww_d     = 1'b1;
                  resp_d    = RESP_DECERR;
                  state_d   = aw_dec_err ? ST_WR_RESP : ST_WR_FWD;
               end else if (grant_rd) begin
                  ch_d    = ar_up[IDX_W-1:0];
                  addr_d  = s_axil.araddr[CH_ADDR_W-1:0];
                  prot_d  = s_axil.arprot;
                  rdata_d = '0;
                  wdog_d  = '0;
                  lww_d   = 1'b0;
                  resp_d  = RESP_DECERR;
                  state_d = ar_dec_err ? ST_RD_RESP : ST_RD_FWD;
               end
            end
            ST_WR_FWD: begin
               aw_done_d = aw_done_q | sel_aw_hs;
               w_done_d  = w_done_q | sel_w_hs;
               if (aw_done_d && w_done_d) state_d = ST_WR_WAIT_B;
            end
            ST_WR_WAIT_B: begin
               if (sel_bvalid) begin
                  resp_d  = ch_bresp[ch_q];
                  state_d = ST_WR_RESP;
               end
            end
            ST_WR_RESP: if (s_axil.bready[0]) state_d = ST_IDLE;
            ST_RD_FWD:  if (sel_ar_hs) state_d = ST_RD_WAIT_R;
            ST_RD_WAIT_R: begin
               if (sel_rvalid) begin
                  resp_d  = ch_rresp[ch_q];
                  rdata_d = ch_rdata[ch_q];
                  state_d = ST_RD_RESP;
               end
            end
            ST_RD_RESP: if (s_axil.rready[0]) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ch_q      <= '0;
         addr_q    <= '0;
         prot_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         wdog_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         lww_q     <= 1'b0;
         to_q      <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         addr_q    <= addr_d;
         prot_q    <= prot_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         wdog_q    <= wdog_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         lww_q     <= lww_d;
         to_q      <= to_d;
      end
   end

endmodule

// File: tb/tb_i2c_axil_chan_router.sv
// tb/tb_i2c_axil_chan_router.sv - directed self-checking bench for the I2C AXI-lite channel router
`timescale 1ns/1ps
module tb_i2c_axil_chan_router;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   i2c_axil_chan_router_if #(.N(1), .ADDR_W(8)) s_if ();
   i2c_axil_chan_router_if #(.N(4), .ADDR_W(4)) m_if ();
   logic [3:0] ch_timeout;

   i2c_axil_chan_router #(
      .N_CH(4), .CH_ADDR_W(4), .S_ADDR_W(8), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .s_axil(s_if), .m_axil(m_if), .ch_timeout(ch_timeout)
   );

   // Downstream channel models: always ready, configurable response delay/stall.
   logic [3:0]  aw_seen, w_seen, r_pend, no_b;
   int          r_cnt [4];
   int          r_dly [4];
   logic [31:0] r_val [4];
   logic        aw_s, w_s;

   assign m_if.awready = 4'hF;
   assign m_if.wready  = 4'hF;
   assign m_if.arready = 4'hF;
   assign m_if.bresp   = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_if.bvalid <= '0;
         m_if.rvalid <= '0;
         m_if.rdata  <= '0;
         m_if.rresp  <= '0;
         aw_seen     <= '0;
         w_seen      <= '0;
         r_pend      <= '0;
         for (int c = 0; c < 4; c++) r_cnt[c] <= 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            aw_s = aw_seen[c] | (m_if.awvalid[c] & m_if.awready[c]);
            w_s  = w_seen[c] | (m_if.wvalid[c] & m_if.wready[c]);
            if (m_if.bvalid[c] && m_if.bready[c]) m_if.bvalid[c] <= 1'b0;
            if (aw_s && w_s && !no_b[c] && !m_if.bvalid[c]) begin
               m_if.bvalid[c] <= 1'b1;
               aw_seen[c]     <= 1'b0;
               w_seen[c]      <= 1'b0;
            end else begin
               aw_seen[c] <= aw_s;
               w_seen[c]  <= w_s;
            end
            if (m_if.rvalid[c] && m_if.rready[c]) m_if.rvalid[c] <= 1'b0;
            if (m_if.arvalid[c] && m_if.arready[c]) begin
               if (r_dly[c] == 0) begin
                  m_if.rvalid[c]        <= 1'b1;
                  m_if.rdata[c*32 +: 32] <= r_val[c];
               end else begin
                  r_pend[c] <= 1'b1;
                  r_cnt[c]  <= r_dly[c] - 1;
               end
            end else if (r_pend[c]) begin
               if (r_cnt[c] == 0) begin
                  r_pend[c]             <= 1'b0;
                  m_if.rvalid[c]        <= 1'b1;
                  m_if.rdata[c*32 +: 32] <= r_val[c];
               end else begin
                  r_cnt[c] <= r_cnt[c] - 1;
               end
            end
         end
      end
   end

   // Downstream activity monitor.
   logic [3:0]  seen_awv, seen_wv, seen_arv, seen_bry;
   logic [3:0]  cap_awaddr [4];
   logic [31:0] cap_wdata [4];
   logic [3:0]  cap_wstrb [4];
   logic [3:0]  cap_araddr [4];

   always @(negedge clk) begin
      seen_awv = seen_awv | m_if.awvalid;
      seen_wv  = seen_wv | m_if.wvalid;
      seen_arv = seen_arv | m_if.arvalid;
      seen_bry = seen_bry | m_if.bready;
      for (int c = 0; c < 4; c++) begin
         if (m_if.awvalid[c]) cap_awaddr[c] = m_if.awaddr[c*4 +: 4];
         if (m_if.wvalid[c]) begin
            cap_wdata[c] = m_if.wdata[c*32 +: 32];
            cap_wstrb[c] = m_if.wstrb[c*4 +: 4];
         end
         if (m_if.arvalid[c]) cap_araddr[c] = m_if.araddr[c*4 +: 4];
      end
   end

   task automatic clear_seen();
      seen_awv = '0;
      seen_wv  = '0;
      seen_arv = '0;
      seen_bry = '0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output int lat, output bit ok);
      bit acc;
      int cyc;
      acc = 0; cyc = 0; ok = 0; resp = 2'bxx; lat = -1;
      @(posedge clk); #1;
      s_if.awaddr = a; s_if.awprot = 3'b010; s_if.wdata = d; s_if.wstrb = st;
      s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.bready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!acc) begin
            if (s_if.awready[0] && s_if.wready[0]) acc = 1;
         end else begin
            cyc++;
            if (s_if.bvalid[0]) begin
               resp = s_if.bresp; lat = cyc; ok = 1;
            end
         end
         @(posedge clk); #1;
         if (acc) begin s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; end
         if (ok) break;
      end
      s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.bready = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output bit ok);
      bit acc;
      int cyc;
      acc = 0; cyc = 0; ok = 0; resp = 2'bxx; data = 'x; lat = -1;
      @(posedge clk); #1;
      s_if.araddr = a; s_if.arprot = 3'b001; s_if.arvalid = 1'b1; s_if.rready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!acc) begin
            if (s_if.arready[0]) acc = 1;
         end else begin
            cyc++;
            if (s_if.rvalid[0]) begin
               resp = s_if.rresp; data = s_if.rdata; lat = cyc; ok = 1;
            end
         end
         @(posedge clk); #1;
         if (acc) s_if.arvalid = 1'b0;
         if (ok) break;
      end
      s_if.arvalid = 1'b0; s_if.rready = 1'b0;
   endtask

   task automatic test_reset();
      logic [19:0] mv;
      rst = 1'b1;
      s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.arvalid = 1'b1;
      repeat (2) @(negedge clk);
      mv = {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
      checks++; if (s_if.awready !== 1'b0 || s_if.wready !== 1'b0 || s_if.arready !== 1'b0) begin
         $display("FAIL reset_ready: aw=%b w=%b ar=%b want 0", s_if.awready, s_if.wready, s_if.arready); failures++; end
      checks++; if (s_if.bvalid !== 1'b0 || s_if.rvalid !== 1'b0) begin
         $display("FAIL reset_valid: b=%b r=%b want 0", s_if.bvalid, s_if.rvalid); failures++; end
      checks++; if ({s_if.bresp, s_if.rresp, s_if.rdata} !== 36'h0) begin
         $display("FAIL reset_payload: bresp=%b rresp=%b rdata=%h want 0", s_if.bresp, s_if.rresp, s_if.rdata); failures++; end
      checks++; if (ch_timeout !== 4'b0000) begin
         $display("FAIL reset_ch_timeout: got %b want 0000", ch_timeout); failures++; end
      checks++; if (mv !== 20'h0) begin
         $display("FAIL reset_downstream: got %h want 0", mv); failures++; end
      s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write_ch2();
      logic [1:0] resp; int lat; bit ok;
      clear_seen();
      do_write(8'h24, 32'h0000_00A5, 4'hF, resp, lat, ok);
      checks++; if (ok !== 1'b1 || resp !== 2'b00) begin
         $display("FAIL wr_ch2_bresp: ok=%0d got %b want 00", ok, resp); failures++; end
      checks++; if (lat !== 3) begin
         $display("FAIL wr_ch2_latency: got %0d want 3", lat); failures++; end
      checks++; if (seen_awv !== 4'b0100 || seen_wv !== 4'b0100) begin
         $display("FAIL wr_ch2_select: awv=%b wv=%b want 0100", seen_awv, seen_wv); failures++; end
      checks++; if (cap_awaddr[2] !== 4'h4 || cap_wdata[2] !== 32'h0000_00A5 || cap_wstrb[2] !== 4'hF) begin
         $display("FAIL wr_ch2_payload: addr=%h data=%h strb=%h want 4 000000a5 f",
                  cap_awaddr[2], cap_wdata[2], cap_wstrb[2]); failures++; end
   endtask

   task automatic test_read_wait();
      logic [31:0] data; logic [1:0] resp; int lat; bit ok;
      clear_seen();
      r_dly[3] = 5; r_val[3] = 32'h1234_5678;
      do_read(8'h38, data, resp, lat, ok);
      checks++; if (ok !== 1'b1 || data !== 32'h1234_5678 || resp !== 2'b00) begin
         $display("FAIL rd_ch3_data: ok=%0d got %h/%b want 12345678/00", ok, data, resp); failures++; end
      checks++; if (seen_arv !== 4'b1000 || cap_araddr[3] !== 4'h8) begin
         $display("FAIL rd_ch3_select: arv=%b addr=%h want 1000 8", seen_arv, cap_araddr[3]); failures++; end
      // accept k, arvalid k+1, rvalid after 5 waits at k+7, upstream k+8
      checks++; if (lat !== 8) begin
         $display("FAIL rd_ch3_latency: got %0d want 8", lat); failures++; end
      r_dly[3] = 0;
   endtask

   task automatic test_decerr();
      logic [31:0] data; logic [1:0] resp; int lat; bit ok;
      clear_seen();
      do_read(8'h48, data, resp, lat, ok);
      checks++; if (ok !== 1'b1 || resp !== 2'b11 || data !== 32'h0) begin
         $display("FAIL rd_decerr: ok=%0d got %b/%h want 11/00000000", ok, resp, data); failures++; end
      do_write(8'hF0, 32'hDEAD_BEEF, 4'hF, resp, lat, ok);
      checks++; if (ok !== 1'b1 || resp !== 2'b11) begin
         $display("FAIL wr_decerr: ok=%0d got %b want 11", ok, resp); failures++; end
      checks++; if ({seen_awv, seen_wv, seen_arv} !== 12'h0) begin
         $display("FAIL decerr_no_downstream: aw=%b w=%b ar=%b want 0", seen_awv, seen_wv, seen_arv); failures++; end
   endtask

   task automatic test_timeout();
      logic [31:0] data; logic [1:0] resp; int lat; bit ok;
      clear_seen();
      no_b[1] = 1'b1;
      do_write(8'h14, 32'h5555_AAAA, 4'h3, resp, lat, ok);
      checks++; if (ok !== 1'b1 || resp !== 2'b10) begin
         $display("FAIL wdog_bresp: ok=%0d got %b want 10", ok, resp); failures++; end
      // forward at k+1, 16 watchdog cycles, upstream response at k+17
      checks++; if (lat !== 17) begin
         $display("FAIL wdog_latency: got %0d want 17", lat); failures++; end
      checks++; if (ch_timeout !== 4'b0010) begin
         $display("FAIL wdog_flag: got %b want 0010", ch_timeout); failures++; end
      checks++; if (m_if.bready !== 4'b0000 || seen_bry !== 4'b0010) begin
         $display("FAIL wdog_bready: now=%b seen=%b want 0000/0010", m_if.bready, seen_bry); failures++; end
      r_val[0] = 32'hCAFE_F00D;
      do_read(8'h0C, data, resp, lat, ok);
      checks++; if (ok !== 1'b1 || data !== 32'hCAFE_F00D || resp !== 2'b00 || lat !== 3) begin
         $display("FAIL wdog_recover: ok=%0d got %h/%b lat %0d want cafef00d/00 lat 3", ok, data, resp, lat); failures++; end
      checks++; if (ch_timeout !== 4'b0010) begin
         $display("FAIL wdog_sticky: got %b want 0010", ch_timeout); failures++; end
   endtask

   task automatic test_back_to_back();
      int wi, ri, n, bc, rc, rbad; bit both, done;
      logic [3:0] order;
      wi = 0; ri = 0; n = 0; bc = 0; rc = 0; rbad = 0; both = 0; done = 0; order = '0;
      r_val[1] = 32'h1111_2222;
      s_if.bready = 1'b1; s_if.rready = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         s_if.awvalid = (wi < 2); s_if.wvalid = (wi < 2);
         s_if.awaddr  = (wi == 0) ? 8'h00 : 8'h04;
         s_if.wdata   = 32'h100 + wi; s_if.wstrb = 4'hF;
         s_if.arvalid = (ri < 2);
         s_if.araddr  = (ri == 0) ? 8'h10 : 8'h14;
         @(negedge clk);
         if (s_if.awvalid[0] && s_if.awready[0]) begin
            if (s_if.arready[0]) both = 1;
            order = {order[2:0], 1'b1}; n++; wi++;
         end
         if (s_if.arvalid[0] && s_if.arready[0]) begin
            order = {order[2:0], 1'b0}; n++; ri++;
         end
         if (s_if.bvalid[0]) bc++;
         if (s_if.rvalid[0]) begin
            rc++;
            if (s_if.rdata !== 32'h1111_2222) rbad++;
         end
         @(posedge clk); #1;
         if (bc == 2 && rc == 2) begin done = 1; break; end
      end
      s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
      s_if.bready = 1'b0; s_if.rready = 1'b0;
      checks++; if (done !== 1'b1 || bc !== 2 || rc !== 2) begin
         $display("FAIL b2b_complete: done=%0d b=%0d r=%0d want 1/2/2", done, bc, rc); failures++; end
      checks++; if (n !== 4 || order !== 4'b1010 || both !== 1'b0) begin
         $display("FAIL b2b_order: n=%0d order=%b both=%0d want 4 1010 0", n, order, both); failures++; end
      checks++; if (rbad !== 0) begin
         $display("FAIL b2b_rdata: bad=%0d want 0", rbad); failures++; end
   endtask

   task automatic test_reset_mid();
      logic [31:0] data; logic [1:0] resp; int lat; bit ok, acc, found;
      logic [19:0] mv;
      acc = 0; found = 0;
      r_dly[0] = 12;
      checks++; if (ch_timeout !== 4'b0010) begin
         $display("FAIL rstmid_pre_flag: got %b want 0010", ch_timeout); failures++; end
      @(posedge clk); #1;
      s_if.araddr = 8'h04; s_if.arvalid = 1'b1; s_if.rready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_if.arready[0]) acc = 1;
         if (m_if.rready[0]) begin found = 1; break; end
         @(posedge clk); #1;
         if (acc) s_if.arvalid = 1'b0;
      end
      checks++; if (found !== 1'b1) begin
         $display("FAIL rstmid_reach_wait: got %0d want 1", found); failures++; end
      #1 rst = 1'b1;
      #1;
      mv = {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
      checks++; if (mv !== 20'h0 || s_if.rvalid !== 1'b0 || s_if.rdata !== 32'h0) begin
         $display("FAIL rstmid_outputs: down=%h rvalid=%b rdata=%h want 0", mv, s_if.rvalid, s_if.rdata); failures++; end
      checks++; if (ch_timeout !== 4'b0000) begin
         $display("FAIL rstmid_flag: got %b want 0000", ch_timeout); failures++; end
      s_if.arvalid = 1'b0; s_if.rready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      r_dly[0] = 0; r_val[0] = 32'h0BAD_F00D;
      do_read(8'h04, data, resp, lat, ok);
      checks++; if (ok !== 1'b1 || data !== 32'h0BAD_F00D || resp !== 2'b00 || lat !== 3) begin
         $display("FAIL rstmid_recover: ok=%0d got %h/%b lat %0d want 0badf00d/00 lat 3", ok, data, resp, lat); failures++; end
   endtask

   initial begin
      rst = 1'b1;
      s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = '0;
      s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = '0; s_if.bready = '0;
      s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = '0; s_if.rready = '0;
      no_b = '0;
      for (int c = 0; c < 4; c++) begin r_dly[c] = 0; r_val[c] = 32'h0; end
      clear_seen();
      test_reset();
      test_write_ch2();
      test_read_wait();
      test_decerr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL bench_time_limit: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
